boot_load_ctrl: RTL and testbench
=================================

// Module: boot_load_ctrl
// PURPOSE
//  Boot sequencer and memory-port owner in front of the single-port word memory shared with Cpu.
//  Holds Cpu in reset and loads a program image from a byte stream (UART RX FIFO) into memory.
//  Releases Cpu and hands it the memory port.
//  Memory read data goes straight from memory to Cpu; this block only muxes the address/write side.
// PARAMETERS
//  AW          30     word-address width of mem_addr / cpu_bus_addr
//  MEM_WORDS   4096   memory size in 32-bit words; image length limit
// PORTS
//  clock           in   1   clock
//  reset           in   1   reset, synchronous, active-high
//  reboot          in   1   one-cycle pulse: re-enter loading, Cpu back into reset
//  rx_valid        in   1   byte stream valid
//  rx_data         in   8   byte stream data
//  rx_ready        out  1   byte accepted when rx_valid & rx_ready at posedge
//  cpu_reset       out  1   registered synchronous reset to Cpu
//  cpu_bus_addr    in   AW  Cpu word address
//  cpu_bus_data_w  in   32  Cpu write data
//  cpu_bus_mask_w  in   4   Cpu byte write mask
//  mem_addr        out  AW  memory word address
//  mem_data_w      out  32  memory write data
//  mem_mask_w      out  4   memory byte write mask (0 = read)
//  booted          out  1   1 while Cpu owns memory (state RUN)
//  error           out  1   image length exceeded MEM_WORDS
// BEHAVIOUR
//  States: LEN, DATA, FLUSH, RUN, ERR. Reset enters LEN with all counters 0.
//  Reset outputs: cpu_reset=1, mem_mask_w=0, mem_addr=0, mem_data_w=0, booted=0, error=0, rx_ready=0 while reset is high.
//  Stream format: 4 bytes N (little-endian u32 word count), then 4*N image bytes.
//    Image words are little-endian; word i goes to address i.
//  rx_ready is combinational: 1 in LEN and DATA, else 0.
//  LEN: shift bytes into length register. On 4th byte:
//    N==0 -> RUN; N>MEM_WORDS -> ERR; else -> DATA with idx=0.
//  DATA: pack bytes (byte 0 -> [7:0]). On 4th byte of a word, at that same edge, register:
//    mem_addr=idx, mem_data_w=word, mem_mask_w=4'b1111.
//    The write is visible exactly one cycle; the mask returns to 0 next edge unless another write follows.
//    Then idx++. If idx was N-1 -> FLUSH.
//  FLUSH: the last write occupies this cycle; next edge -> RUN.
//  RUN: mem_addr/data/mask = cpu_bus_* combinationally.
//    cpu_reset is registered: it falls at the edge entering RUN, so the first RUN cycle has cpu_reset=0. booted=1.
//  ERR: rx_ready=0, cpu_reset=1, error=1, mem_mask_w=0; exit only by reset or reboot.
//  While not in RUN, Cpu bus inputs are ignored; mem_mask_w is nonzero only during loader writes.
//  reboot in any state -> LEN, cpu_reset=1 at next edge; partial length/word and error are discarded.
//    A byte offered in the same cycle is NOT accepted: rx_ready is forced 0 while reboot=1.
//  reset has priority over reboot. reset mid-load abandons the image; memory contents are undefined.
//  idx width: $clog2(MEM_WORDS+1). The N comparison is done on the full 32 bits; no wrap.
//  Stalls (rx_valid=0) between any bytes are legal and hold all state.
// STRUCTURE
//  Package boot_pkg: typedef enum logic[2:0] boot_state_t {LEN,DATA,FLUSH,RUN,ERR}; localparam BYTES_PER_WORD=4.
//  Sub-module boot_word_packer:
//    byte-lane counter + 32-bit shift assembler; outputs word and word_done; clear input used by reboot/state change.
//  Top holds the FSM, idx/N counters, write registers, and the output mux.
// TESTING
//  1. Stream 01 00 00 00, 13 05 10 00 -> one cycle of mem_mask_w=1111, addr=0, data=32'h00100513;
//     2 edges after the last byte cpu_reset=0, booted=1.
//  2. N=0 (00 00 00 00) -> no memory write; cpu_reset falls at the edge after the 4th byte.
//  3. N=MEM_WORDS+1 -> error=1, rx_ready=0, cpu_reset stays 1; then pulse reboot -> LEN, error=0, rx_ready=1.
//  4. N=3 with random rx_valid gaps -> writes to addresses 0,1,2 in order with correct words;
//     in RUN, mem_addr follows cpu_bus_addr and mem_mask_w follows cpu_bus_mask_w.
//  5. reboot during DATA after 2 bytes of word 1 -> partial word dropped, no write;
//     a new stream loads correctly from address 0.
//  6. reset and reboot asserted together mid-RUN -> reset values above; the next stream loads normally.

Source files
------------

// File: rtl/boot_pkg.sv
// Shared types for the boot loader: FSM state encoding and stream framing constants.
package boot_pkg;

    typedef enum logic [2:0] {LEN, DATA, FLUSH, RUN, ERR} boot_state_t;

    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/boot_word_packer.sv
// Assembles little-endian 32-bit words from a byte stream; word is valid with word_done
// on the cycle the final byte is offered, so the consumer can register it at that edge.
module boot_word_packer
    import boot_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_done
);

    localparam int LW = $clog2(BYTES_PER_WORD);
    localparam int AccW = 8 * (BYTES_PER_WORD - 1);

    logic [LW-1:0]   lane;
    logic [AccW-1:0] acc;

    // New bytes enter at the top and shift down, so byte 0 ends in [7:0].
    assign word_done = byte_valid && (lane == LW'(BYTES_PER_WORD - 1));
    assign word      = {byte_data, acc};

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            lane <= '0;
            acc  <= '0;
        end else if (byte_valid) begin
            lane <= word_done ? '0 : lane + LW'(1);
            acc  <= {byte_data, acc[AccW-1:8]};
        end
    end

endmodule

// File: rtl/boot_load_ctrl.sv
// Boot sequencer: loads a length-prefixed image from the byte stream into memory while
// Cpu is held in reset, then hands the memory address/write port over to Cpu.
module boot_load_ctrl
    import boot_pkg::*;
#(
    parameter int AW        = 30,
    parameter int MEM_WORDS = 4096
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          reboot,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
    output logic          rx_ready,
    output logic          cpu_reset,
    input  logic [AW-1:0] cpu_bus_addr,
    input  logic [31:0]   cpu_bus_data_w,
    input  logic [3:0]    cpu_bus_mask_w,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_data_w,
    output logic [3:0]    mem_mask_w,
    output logic          booted,
    output logic          error
);

    localparam int IW = $clog2(MEM_WORDS + 1);

    boot_state_t   state, state_next;
    logic [IW-1:0] idx, last_idx;
    logic [IW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic [3:0]    wr_mask;
    logic          cpu_reset_q;
    logic          loading, accept;
    logic [31:0]   word;
    logic          word_done;

    assign loading  = (state == LEN) || (state == DATA);
    assign rx_ready = loading && !reboot && !reset;
    assign accept   = rx_valid && rx_ready;

    // The same packer frames the length field and the image words.
    boot_word_packer u_packer (
        .clock      (clock),
        .reset      (reset),
        .clear      (reboot || !loading),
        .byte_valid (accept),
        .byte_data  (rx_data),
        .word       (word),
        .word_done  (word_done)
    );

    always_ff @(posedge clock) begin
        if (reset) state <= LEN;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            LEN: if (word_done) begin
                if (word == 32'd0)                 state_next = RUN;
                else if (word > 32'(MEM_WORDS))    state_next = ERR;
                else                               state_next = DATA;
            end
            DATA:    if (word_done && idx == last_idx) state_next = FLUSH;
            FLUSH:   state_next = RUN;
            default: state_next = state;
        endcase
        if (reboot) state_next = LEN;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            idx         <= '0;
            last_idx    <= '0;
            wr_addr     <= '0;
            wr_data     <= '0;
            wr_mask     <= '0;
            cpu_reset_q <= 1'b1;
        end else begin
            // Registered off the next state so Cpu leaves reset on the first RUN cycle.
            cpu_reset_q <= (state_next != RUN);
            wr_mask     <= '0;
            if (reboot) begin
                idx <= '0;
            end else if (state == LEN && word_done) begin
                idx      <= '0;
                last_idx <= IW'(word - 32'd1);
            end else if (state == DATA && word_done) begin
                wr_addr <= idx;
                wr_data <= word;
                wr_mask <= 4'b1111;
                idx     <= idx + IW'(1);
            end
        end
    end

    always_comb begin
        if (state == RUN) begin
            mem_addr   = cpu_bus_addr;
            mem_data_w = cpu_bus_data_w;
            mem_mask_w = cpu_bus_mask_w;
        end else begin
            mem_addr   = AW'(wr_addr);
            mem_data_w = wr_data;
            mem_mask_w = wr_mask;
        end
    end

    assign cpu_reset = cpu_reset_q;
    assign booted    = (state == RUN);
    assign error     = (state == ERR);

endmodule

// File: tb/tb_boot_load_ctrl.sv
// Randomized bench for boot_load_ctrl: image streams with random gaps, observed memory
// writes compared against the words the stream encodes, plus reboot/reset/overflow cases.
module tb_boot_load_ctrl;

    localparam int AW = 30;
    localparam int MEM_WORDS = 4096;

    logic          clock = 1'b0;
    logic          reset, reboot, rx_valid, rx_ready, cpu_reset, booted, error;
    logic [7:0]    rx_data;
    logic [AW-1:0] cpu_bus_addr, mem_addr;
    logic [31:0]   cpu_bus_data_w, mem_data_w;
    logic [3:0]    cpu_bus_mask_w, mem_mask_w;

    boot_load_ctrl #(.AW(AW), .MEM_WORDS(MEM_WORDS)) dut (
        .clock          (clock),
        .reset          (reset),
        .reboot         (reboot),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .rx_ready       (rx_ready),
        .cpu_reset      (cpu_reset),
        .cpu_bus_addr   (cpu_bus_addr),
        .cpu_bus_data_w (cpu_bus_data_w),
        .cpu_bus_mask_w (cpu_bus_mask_w),
        .mem_addr       (mem_addr),
        .mem_data_w     (mem_data_w),
        .mem_mask_w     (mem_mask_w),
        .booted         (booted),
        .error          (error)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic [3:0]    mask;
    } wr_t;

    wr_t         cap[$];
    logic [31:0] img[$];
    int          checks = 0;
    int          errors = 0;
    bit          gaps = 1'b0;

    // Every loader write seen on the memory port while Cpu does not own it.
    always @(negedge clock) begin
        if (mem_mask_w != 4'b0000 && !booted)
            cap.push_back('{mem_addr, mem_data_w, mem_mask_w});
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        while (gaps && $urandom_range(0, 2) == 0) begin
            rx_valid = 1'b0;
            @(negedge clock);
        end
        rx_valid = 1'b1;
        rx_data  = b;
        #1;
        while (!rx_ready && n < 20) begin
            @(negedge clock);
            #1;
            n++;
        end
        if (!rx_ready) begin
            checks++; errors++;
            $display("FAIL send_byte: rx_ready stuck at 0 for byte %h", b);
        end
        @(negedge clock);
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8]);
    endtask

    task automatic pulse_reboot();
        reboot = 1'b1;
        @(negedge clock);
        reboot = 1'b0;
    endtask

    task automatic randomize_cpu_bus();
        cpu_bus_addr   = AW'($urandom);
        cpu_bus_data_w = $urandom;
        cpu_bus_mask_w = 4'($urandom_range(1, 15));
    endtask

    // Streams img from LEN and checks the writes it must produce and the handover to Cpu.
    task automatic run_load();
        int n = img.size();
        cap.delete();
        randomize_cpu_bus();
        send_word(32'(n));
        foreach (img[i]) send_word(img[i]);
        if (n == 0) begin
            checks++;
            if (cpu_reset !== 1'b0 || booted !== 1'b1) begin
                errors++;
                $display("FAIL n0_handover: cpu_reset=%b booted=%b expected 0/1", cpu_reset, booted);
            end
        end else begin
            checks++;
            if (booted !== 1'b0 || mem_mask_w !== 4'b1111 || cpu_reset !== 1'b1) begin
                errors++;
                $display("FAIL flush_cycle: booted=%b mask=%b cpu_reset=%b expected 0/1111/1",
                         booted, mem_mask_w, cpu_reset);
            end
            @(negedge clock);
            checks++;
            if (booted !== 1'b1 || cpu_reset !== 1'b0) begin
                errors++;
                $display("FAIL run_entry: booted=%b cpu_reset=%b expected 1/0", booted, cpu_reset);
            end
        end
        checks++;
        if (cap.size() != n) begin
            errors++;
            $display("FAIL write_count: got %0d expected %0d", cap.size(), n);
        end
        for (int i = 0; i < n && i < cap.size(); i++) begin
            checks++;
            if (cap[i].addr !== AW'(i) || cap[i].data !== img[i] || cap[i].mask !== 4'b1111) begin
                errors++;
                $display("FAIL write[%0d]: got addr=%0d data=%h mask=%b expected addr=%0d data=%h mask=1111",
                         i, cap[i].addr, cap[i].data, cap[i].mask, i, img[i]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; reboot = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        randomize_cpu_bus();
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (cpu_reset !== 1'b1 || mem_mask_w !== 4'b0 || mem_addr !== '0 || mem_data_w !== 32'b0 ||
            booted !== 1'b0 || error !== 1'b0 || rx_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: cpu_reset=%b mask=%b addr=%h data=%h booted=%b error=%b rx_ready=%b",
                     cpu_reset, mem_mask_w, mem_addr, mem_data_w, booted, error, rx_ready);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL len_ready: rx_ready=%b expected 1", rx_ready);
        end
        @(negedge clock);
    endtask

    task automatic test_single_word();
        gaps = 1'b0;
        img = '{32'h00100513};
        run_load();
        pulse_reboot();
    endtask

    task automatic test_len_zero();
        img = '{};
        run_load();
        pulse_reboot();
    endtask

    task automatic test_overflow();
        cap.delete();
        send_word(32'(MEM_WORDS + 1));
        rx_valid = 1'b1; rx_data = 8'h5a;
        #1;
        checks++;
        if (error !== 1'b1 || rx_ready !== 1'b0 || cpu_reset !== 1'b1 || booted !== 1'b0) begin
            errors++;
            $display("FAIL overflow_err: error=%b rx_ready=%b cpu_reset=%b booted=%b expected 1/0/1/0",
                     error, rx_ready, cpu_reset, booted);
        end
        repeat (3) @(negedge clock);
        checks++;
        if (error !== 1'b1 || cap.size() != 0) begin
            errors++;
            $display("FAIL err_hold: error=%b writes=%0d expected 1/0", error, cap.size());
        end
        rx_valid = 1'b0;
        pulse_reboot();
        #1;
        checks++;
        if (error !== 1'b0 || rx_ready !== 1'b1 || cpu_reset !== 1'b1) begin
            errors++;
            $display("FAIL reboot_from_err: error=%b rx_ready=%b cpu_reset=%b expected 0/1/1",
                     error, rx_ready, cpu_reset);
        end
        // A byte offered alongside reboot must be ignored.
        reboot = 1'b1; rx_valid = 1'b1; rx_data = 8'hff;
        #1;
        checks++;
        if (rx_ready !== 1'b0) begin
            errors++;
            $display("FAIL reboot_blocks_rx: rx_ready=%b expected 0", rx_ready);
        end
        @(negedge clock);
        reboot = 1'b0; rx_valid = 1'b0;
        img = '{$urandom};
        run_load();
    endtask

    task automatic test_run_bus();
        for (int k = 0; k < 4; k++) begin
            randomize_cpu_bus();
            if (k == 3) cpu_bus_mask_w = 4'b0000;
            #1;
            checks++;
            if (mem_addr !== cpu_bus_addr || mem_data_w !== cpu_bus_data_w || mem_mask_w !== cpu_bus_mask_w) begin
                errors++;
                $display("FAIL run_mux: got %h/%h/%b expected %h/%h/%b", mem_addr, mem_data_w, mem_mask_w,
                         cpu_bus_addr, cpu_bus_data_w, cpu_bus_mask_w);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_gapped_three();
        pulse_reboot();
        gaps = 1'b1;
        img = '{$urandom, $urandom, $urandom};
        run_load();
        test_run_bus();
    endtask

    task automatic test_reboot_in_data();
        logic [31:0] w0, w1;
        pulse_reboot();
        cap.delete();
        w0 = $urandom; w1 = $urandom;
        send_word(32'd2);
        send_word(w0);
        send_byte(w1[7:0]);
        send_byte(w1[15:8]);
        pulse_reboot();
        repeat (2) @(negedge clock);
        checks++;
        if (cap.size() != 1 || cap[0].data !== w0 || cpu_reset !== 1'b1 || booted !== 1'b0) begin
            errors++;
            $display("FAIL reboot_drop: writes=%0d cpu_reset=%b booted=%b expected 1/1/0",
                     cap.size(), cpu_reset, booted);
        end
        img = '{$urandom, $urandom};
        run_load();
    endtask

    task automatic test_reset_and_reboot();
        randomize_cpu_bus();
        reset = 1'b1; reboot = 1'b1;
        @(negedge clock);
        #1;
        checks++;
        if (cpu_reset !== 1'b1 || mem_mask_w !== 4'b0 || mem_addr !== '0 || mem_data_w !== 32'b0 ||
            booted !== 1'b0 || error !== 1'b0 || rx_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_over_reboot: cpu_reset=%b mask=%b addr=%h data=%h booted=%b error=%b rx_ready=%b",
                     cpu_reset, mem_mask_w, mem_addr, mem_data_w, booted, error, rx_ready);
        end
        @(negedge clock);
        reset = 1'b0; reboot = 1'b0;
        img = '{$urandom, $urandom, $urandom, $urandom};
        run_load();
    endtask

    task automatic test_random_loads();
        for (int r = 0; r < 4; r++) begin
            pulse_reboot();
            gaps = 1'($urandom_range(0, 1));
            img = '{};
            for (int i = 0; i < $urandom_range(1, 6); i++) img.push_back($urandom);
            run_load();
            test_run_bus();
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_len_zero();
        test_overflow();
        test_gapped_three();
        test_reboot_in_data();
        test_reset_and_reboot();
        test_random_loads();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
